au_seq: RTL and testbench
=========================

// Module: au_seq
// PURPOSE
//  Parametrised, handshaked successor of the 16-bit combinational arithmetic unit. Adds
//  valid/ready flow control, iterative one-bit-per-cycle shifts and N/Z flags, and fixes
//  signed-overflow detection. Sits between the register-read and writeback stages of the
//  CPU datapath; the sequencer stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH    16                operand/result width; power of two, >= 4
//  SHAMT_W  $clog2(WIDTH)+1   derived (localparam) shift-counter width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation offered
//  in_ready   out  1      block can accept (IDLE only)
//  opcode     in   3      000 ADD, 001 SUB, 010/011 NOP|MUL, 100 SHL, 101 SHR, 110 ROL, 111 SAR
//  arg1       in   WIDTH  first operand / shiftee
//  arg2       in   WIDTH  second operand / shift amount (unsigned)
//  out_valid  out  1      result + flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  result
//  carry      out  1      carry / borrow / last bit shifted out
//  overflow   out  1      signed overflow (ADD/SUB only)
//  negative   out  1      result[WIDTH-1]
//  zero       out  1      result == 0
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, result/flags=0. rst mid-operation aborts it;
//    result is discarded, IDLE on the next cycle.
//  - FSM IDLE -> (in_valid) -> BUSY or DONE; BUSY -> (count==0) -> DONE;
//    DONE -> (out_ready) -> IDLE. Inputs are latched on accept. No overlap: in_ready=0 in BUSY/DONE.
//  - ADD/SUB/NOP and shift amount 0: out_valid in the cycle after accept (latency 1).
//  - ADD/SUB: (WIDTH+1)-bit unsigned arithmetic. carry=bit WIDTH (SUB: 1 iff arg1<arg2).
//    overflow: ADD = s1==s2 && so!=s1; SUB = s1!=s2 && so!=s1.
//  - Shifts: amount = min(arg2, WIDTH) for SHL/SHR/SAR; arg2 mod WIDTH for ROL. One bit per
//    BUSY cycle; latency = 1+amount. carry = last bit shifted/rotated out; 0 if amount==0.
//    overflow=0 for all shifts.
//  - SHL/SHR with amount WIDTH: result 0, carry = arg1[0] / arg1[WIDTH-1].
//  - SAR with amount WIDTH: result all sign bits, carry = sign.
//  - In DONE, result and flags are held stable until out_ready; negative/zero derive from result.
// CONFIGURATION
//  AU_MUL_EN defined:
//   - 010 MUL: low WIDTH bits of the unsigned product; carry = |high half.
//   - 011 MULHU: high WIDTH bits; carry=0. Both use shift-add, latency WIDTH+1; overflow=0.
//  AU_MUL_EN undefined:
//   - 010/011 are NOP: result=arg1, carry=overflow=0, latency 1.
//   - No multiplier registers are instantiated.
// STRUCTURE
//  - Package au_pkg: opcode localparams (AU_ADD..AU_SAR, AU_MUL, AU_MULHU) and FSM state
//    encoding (S_IDLE, S_BUSY, S_DONE).
//  - Sub-module au_shift_step: combinational one-bit SHL/SHR/ROL/SAR step returning
//    {bit_out, next_value}.
// TESTING (WIDTH=16)
//  1. ADD 0x7FFF+0x0001 -> 0x8000, c=0 v=1 n=1 z=0; out_valid 1 cycle after accept.
//  2. SUB 0x0000-0x0001 -> 0xFFFF, c=1 v=0; SUB 0x8000-0x0001 -> 0x7FFF, v=1.
//  3. SAR 0x8000 by 3 -> 0xF000, c=0, latency 4; SHL 0x8001 by 1 -> 0x0002, c=1;
//     SHR 0x0001 by 20 -> 0x0000, c=0, z=1, latency 17.
//  4. ROL 0x1234 by 20 -> 0x2341, latency 5; ROL by 16 -> 0x1234, c=0, latency 1.
//  5. Hold out_ready=0 for 5 cycles: result stable, in_ready=0. Assert rst during a 10-bit
//     shift: next cycle out_valid=0, in_ready=1; a following ADD completes correctly.
//  6. AU_MUL_EN: MUL 0x0100*0x0100 -> 0x0000 c=1; MULHU -> 0x0001; latency 17. Without the
//     macro: opcode 010 with arg1=0xABCD -> 0xABCD, latency 1.

Source files
------------

// File: rtl/au_pkg.sv
// Shared opcode and FSM state definitions for the sequential arithmetic unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package au_pkg;

  // Operation codes carried on the 3-bit opcode port
  localparam logic [2:0] AU_ADD   = 3'b000;
  localparam logic [2:0] AU_SUB   = 3'b001;
  localparam logic [2:0] AU_MUL   = 3'b010;  // NOP when the multiplier is not built
  localparam logic [2:0] AU_MULHU = 3'b011;  // NOP when the multiplier is not built
  localparam logic [2:0] AU_SHL   = 3'b100;
  localparam logic [2:0] AU_SHR   = 3'b101;
  localparam logic [2:0] AU_ROL   = 3'b110;
  localparam logic [2:0] AU_SAR   = 3'b111;

  // Control FSM: accept in IDLE, iterate in BUSY, present the result in DONE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/au_shift_step.sv
// One-bit shift/rotate step (SHL, SHR, ROL, SAR) selected by opcode[1:0] of a shift op.
// Latency: combinational.
// Backpressure: none; the caller decides when to register next_value.
module au_shift_step
  import au_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] value,
  output logic             bit_out,
  output logic [WIDTH-1:0] next_value
);

  // Shift-class opcodes all have bit 2 set, so mode is their low two bits
  always_comb begin
    bit_out    = 1'b0;
    next_value = value;
    case ({1'b1, mode})
      AU_SHL: begin
        bit_out    = value[WIDTH-1];
        next_value = {value[WIDTH-2:0], 1'b0};
      end
      AU_SHR: begin
        bit_out    = value[0];
        next_value = {1'b0, value[WIDTH-1:1]};
      end
      AU_ROL: begin
        bit_out    = value[WIDTH-1];
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
      end
      AU_SAR: begin
        bit_out    = value[0];
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
      end
      default: begin
        bit_out    = 1'b0;
        next_value = value;
      end
    endcase
  end

endmodule

// File: rtl/au_seq.sv
// Handshaked arithmetic unit: ADD/SUB/NOP single-step, shifts one bit per cycle, optional shift-add MUL.
// Latency: 1 for ADD/SUB/NOP and zero-amount shifts, 1+amount for shifts, WIDTH+1 for MUL/MULHU.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready. Option macro: AU_MUL_EN.
module au_seq
  import au_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  localparam int SHAMT_W = $clog2(WIDTH) + 1;
  localparam int LOG_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   W_LIM = WIDTH'(WIDTH);
  localparam logic [SHAMT_W-1:0] W_CNT = SHAMT_W'(WIDTH);

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;

  // Single-cycle arithmetic on the offered operands, one guard bit for carry/borrow
  logic [WIDTH:0]       sum, diff;
  logic [SHAMT_W-1:0]   sat_amt, rol_amt;

  assign sum  = {1'b0, arg1} + {1'b0, arg2};
  assign diff = {1'b0, arg1} - {1'b0, arg2};

  // Linear shifts saturate at WIDTH (all bits gone); rotates wrap modulo WIDTH
  assign sat_amt = (arg2 >= W_LIM) ? W_CNT : arg2[SHAMT_W-1:0];
  assign rol_amt = {1'b0, arg2[LOG_W-1:0]};

  // The working value for shifts lives in result_q; the step unit advances it one bit
  logic             step_bit;
  logic [WIDTH-1:0] step_value;

  au_shift_step #(.WIDTH(WIDTH)) u_step (
    .mode       (op_q[1:0]),
    .value      (result_q),
    .bit_out    (step_bit),
    .next_value (step_value)
  );

`ifdef AU_MUL_EN
  // Shift-add multiplier: {mhi, mlo} accumulates the product while mlo drains the multiplier
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mhi_q, mhi_d;
  logic [WIDTH-1:0] mlo_q, mlo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;

  assign mul_sum    = mlo_q[0] ? ({1'b0, mhi_q} + {1'b0, mcand_q}) : {1'b0, mhi_q};
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], mlo_q[WIDTH-1:1]};
`endif

  // Next-state, datapath next values and handshake outputs
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef AU_MUL_EN
    mcand_d   = mcand_q;
    mhi_d     = mhi_q;
    mlo_d     = mlo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d     = opcode;
          result_d = arg1;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          count_d  = '0;
          state_d  = S_DONE;
          case (opcode)
            AU_ADD: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              ovf_d    = (arg1[WIDTH-1] == arg2[WIDTH-1]) &&
                         (sum[WIDTH-1] != arg1[WIDTH-1]);
            end
            AU_SUB: begin
              result_d = diff[WIDTH-1:0];
              carry_d  = diff[WIDTH];
              ovf_d    = (arg1[WIDTH-1] != arg2[WIDTH-1]) &&
                         (diff[WIDTH-1] != arg1[WIDTH-1]);
            end
`ifdef AU_MUL_EN
            AU_MUL, AU_MULHU: begin
              mcand_d = arg1;
              mhi_d   = '0;
              mlo_d   = arg2;
              count_d = W_CNT;
              state_d = S_BUSY;
            end
`endif
            AU_SHL, AU_SHR, AU_SAR: begin
              count_d = sat_amt;
              if (sat_amt != '0) state_d = S_BUSY;
            end
            AU_ROL: begin
              count_d = rol_amt;
              if (rol_amt != '0) state_d = S_BUSY;
            end
            default: begin
              // NOP: pass arg1 through with clear flags
            end
          endcase
        end
      end

      S_BUSY: begin
        // The step taken in the last BUSY cycle lands together with the move to DONE
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) state_d = S_DONE;
        if (op_q[2]) begin
          result_d = step_value;
          carry_d  = step_bit;
        end
`ifdef AU_MUL_EN
        else begin
          mhi_d = mul_hi_nxt;
          mlo_d = mul_lo_nxt;
          if (count_q == SHAMT_W'(1)) begin
            result_d = op_q[0] ? mul_hi_nxt : mul_lo_nxt;
            carry_d  = op_q[0] ? 1'b0 : (|mul_hi_nxt);
          end
        end
`endif
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= AU_ADD;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef AU_MUL_EN
  // Multiplier operand and partial-product registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mhi_q   <= '0;
      mlo_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      mhi_q   <= mhi_d;
      mlo_q   <= mlo_d;
    end
  end
`endif

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign negative = result_q[WIDTH-1];
  assign zero     = ~|result_q;

endmodule

// File: tb/tb_au_seq.sv
// Self-checking bench for au_seq (WIDTH=16): directed vectors, handshake scenarios, randomized ops.
// Latency: measured from the accepting edge to the first cycle out_valid is seen.
// Backpressure: exercised by holding out_ready low with a competing offer on the input.
module tb_au_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [15:0] arg1;
  logic [15:0] arg2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic        negative;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  au_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .arg1      (arg1),
    .arg2      (arg2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        c;
    logic        v;
    int          lat;
  } vec_t;

  // Reference model from the arithmetic rules: wide integers, shifts of concatenations
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output logic v,
                                output int lat);
    logic [31:0]        t;
    logic signed [31:0] ts;
    int                 amt;
    r = a; c = 1'b0; v = 1'b0; lat = 1;
    amt = (b > 16'd16) ? 16 : int'(b);
    case (op)
      3'd0: begin
        t = 32'(a) + 32'(b);
        r = t[15:0]; c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2, 3'd3: begin
`ifdef AU_MUL_EN
        t = 32'(a) * 32'(b);
        if (op == 3'd2) begin r = t[15:0]; c = |t[31:16]; end
        else begin r = t[31:16]; c = 1'b0; end
        lat = 17;
`endif
      end
      3'd4: begin t = {16'h0, a} << amt; r = t[15:0]; c = t[16]; lat = 1 + amt; end
      3'd5: begin t = {a, 16'h0} >> amt; r = t[31:16]; c = t[15]; lat = 1 + amt; end
      3'd7: begin ts = $signed({a, 16'h0}) >>> amt; r = ts[31:16]; c = ts[15]; lat = 1 + amt; end
      default: begin
        amt = int'(b % 16'd16);
        t = {a, a} << amt; r = t[31:16];
        c = (amt != 0) && r[0];
        lat = 1 + amt;
      end
    endcase
  endfunction

  // Offer one op from IDLE, wait (bounded) for out_valid, capture outputs; -1 latency on timeout
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic c, output logic v,
                       output logic n, output logic z, output int lat);
    opcode = op; arg1 = a; arg2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = result; c = carry; v = overflow; n = negative; z = zero;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t e);
    logic [15:0] r; logic c, v, n, z; int lat;
    issue(e.op, e.a, e.b, r, c, v, n, z, lat);
    n_checks++;
    if ({r, c, v, n, z} !== {e.r, e.c, e.v, e.r[15], (e.r == 16'h0)} || lat != e.lat) begin
      n_fail++;
      $display("FAIL %s: got r=%h c=%b v=%b n=%b z=%b lat=%0d, want r=%h c=%b v=%b n=%b z=%b lat=%0d",
               e.name, r, c, v, n, z, lat, e.r, e.c, e.v, e.r[15], (e.r == 16'h0), e.lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 3'd0; arg1 = 16'h0; arg2 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, result, carry, overflow, negative, zero} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b r=%h c=%b v=%b n=%b z=%b, want rdy=1 vld=0 r=0000 c=0 v=0 n=0 z=1",
               in_ready, out_valid, result, carry, overflow, negative, zero);
    end
  endtask

  task automatic test_add_sub();
    vec_t q[$];
    q.push_back('{"add_ovf",    3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1});
    q.push_back('{"sub_borrow", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1});
    q.push_back('{"sub_ovf",    3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1});
    q.push_back('{"add_carry",  3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1});
    foreach (q[i]) run_vec(q[i]);
  endtask

  task automatic test_shifts();
    vec_t q[$];
    q.push_back('{"sar_3",      3'd7, 16'h8000, 16'd3,    16'hF000, 1'b0, 1'b0, 4});
    q.push_back('{"shl_1",      3'd4, 16'h8001, 16'd1,    16'h0002, 1'b1, 1'b0, 2});
    q.push_back('{"shr_20",     3'd5, 16'h0001, 16'd20,   16'h0000, 1'b0, 1'b0, 17});
    q.push_back('{"rol_20",     3'd6, 16'h1234, 16'd20,   16'h2341, 1'b1, 1'b0, 5});
    q.push_back('{"rol_16",     3'd6, 16'h1234, 16'd16,   16'h1234, 1'b0, 1'b0, 1});
    q.push_back('{"shl_16",     3'd4, 16'h0001, 16'd16,   16'h0000, 1'b1, 1'b0, 17});
    q.push_back('{"shr_full",   3'd5, 16'h8000, 16'd16,   16'h0000, 1'b1, 1'b0, 17});
    q.push_back('{"sar_ffff",   3'd7, 16'h8000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17});
    q.push_back('{"shl_0",      3'd4, 16'hA5A5, 16'd0,    16'hA5A5, 1'b0, 1'b0, 1});
    foreach (q[i]) run_vec(q[i]);
  endtask

  task automatic test_mul_nop();
    vec_t q[$];
`ifdef AU_MUL_EN
    q.push_back('{"mul_lo",  3'd2, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 17});
    q.push_back('{"mulhu",   3'd3, 16'h0100, 16'h0100, 16'h0001, 1'b0, 1'b0, 17});
    q.push_back('{"mul_max", 3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 17});
`else
    q.push_back('{"nop_010", 3'd2, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1});
    q.push_back('{"nop_011", 3'd3, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1});
`endif
    foreach (q[i]) run_vec(q[i]);
  endtask

  task automatic test_backpressure();
    logic [15:0] r; logic c, v, n, z; int lat;
    out_ready = 1'b0;
    issue(3'd0, 16'h1234, 16'h1111, r, c, v, n, z, lat);
    n_checks++;
    if (r !== 16'h2345 || lat != 1) begin
      n_fail++;
      $display("FAIL bp_first: got r=%h lat=%0d, want r=2345 lat=1", r, lat);
    end
    // A competing offer must not be taken while the result is held
    opcode = 3'd1; arg1 = 16'hFFFF; arg2 = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result, carry, overflow} !== {1'b1, 1'b0, 16'h2345, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b r=%h c=%b v=%b, want vld=1 rdy=0 r=2345 c=0 v=0",
                 i, out_valid, in_ready, result, carry, overflow);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] r; logic c, v, n, z; int lat; int seen;
    opcode = 3'd4; arg1 = 16'h00FF; arg2 = 16'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_busy: got vld=%b rdy=%b, want vld=0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL abort_reset: got vld=%b rdy=%b r=%h, want vld=0 rdy=1 r=0000", out_valid, in_ready, result);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_late_result: got %0d valid cycles, want 0", seen);
    end
    issue(3'd0, 16'h0003, 16'h0004, r, c, v, n, z, lat);
    n_checks++;
    if ({r, c, v, n, z} !== {16'h0007, 1'b0, 1'b0, 1'b0, 1'b0} || lat != 1) begin
      n_fail++;
      $display("FAIL abort_then_add: got r=%h c=%b v=%b n=%b z=%b lat=%0d, want r=0007 c=0 v=0 n=0 z=0 lat=1",
               r, c, v, n, z, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] r, a, b, er; logic c, v, n, z, ec, ev; int lat, elat;
    logic [2:0] op;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
      b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      model(op, a, b, er, ec, ev, elat);
      issue(op, a, b, r, c, v, n, z, lat);
      n_checks++;
      if ({r, c, v, n, z} !== {er, ec, ev, er[15], (er == 16'h0)} || lat != elat) begin
        n_fail++;
        $display("FAIL rand_%0d op=%0d a=%h b=%h: got r=%h c=%b v=%b n=%b z=%b lat=%0d, want r=%h c=%b v=%b n=%b z=%b lat=%0d",
                 i, op, a, b, r, c, v, n, z, lat, er, ec, ev, er[15], (er == 16'h0), elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_mul_nop();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
